// File: rtl/cla_pkg.sv
// Shared constants and word type for the registered 32-bit carry-lookahead adder.
package cla_pkg;

   localparam int unsigned CLA_WIDTH   = 32;
   localparam int unsigned CLA_GROUP   = 4;
   localparam int unsigned CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

   typedef logic [CLA_WIDTH-1:0] cla_word_t;

endpackage : cla_pkg

// File: rtl/cla_group4.sv
// First-level 4-bit lookahead group: internal carries, sum bits, and group generate/propagate.
module cla_group4
   import cla_pkg::*;
(
   input  logic [CLA_GROUP-1:0] a,
   input  logic [CLA_GROUP-1:0] b,
   input  logic                 cin,
   output logic [CLA_GROUP-1:0] sum_c,
   output logic                 g_c,
   output logic                 p_c
);

   logic [CLA_GROUP-1:0] g;
   logic [CLA_GROUP-1:0] p;
   logic [CLA_GROUP-1:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every internal carry is a flat sum of products of cin, g and p.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   assign sum_c = p ^ c;

   assign g_c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
   assign p_c = &p;

endmodule : cla_group4

// File: rtl/carry_look_ahead.sv
// Registered 32-bit two-level carry-lookahead adder (one-cycle latency).
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output.
module carry_look_ahead
   import cla_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   output cla_word_t            sum,
   output logic                 c_out,
   input  logic                 c_in,
   input  cla_word_t            in_1,
   input  cla_word_t            in_2
`ifdef CLA_OVERFLOW_EN
   ,
   output logic                 overflow
`endif
);

   logic [CLA_NGROUPS-1:0] grp_g;
   logic [CLA_NGROUPS-1:0] grp_p;
   logic [CLA_NGROUPS:0]   grp_c;
   cla_word_t              sum_c;

   for (genvar gi = 0; gi < CLA_NGROUPS; gi++) begin : g_grp
      cla_group4 u_grp (
         .a     (in_1[gi*CLA_GROUP +: CLA_GROUP]),
         .b     (in_2[gi*CLA_GROUP +: CLA_GROUP]),
         .cin   (grp_c[gi]),
         .sum_c (sum_c[gi*CLA_GROUP +: CLA_GROUP]),
         .g_c   (grp_g[gi]),
         .p_c   (grp_p[gi])
      );
   end

   // Second level: each group carry is an OR of AND-terms over G/P and c_in, no chaining.
   always_comb begin
      logic acc;
      logic term;
      grp_c    = '0;
      acc      = 1'b0;
      term     = 1'b0;
      grp_c[0] = c_in;
      for (int unsigned j = 0; j < CLA_NGROUPS; j++) begin
         acc = c_in;
         for (int unsigned i = 0; i <= j; i++) begin
            acc = acc & grp_p[i];
         end
         for (int unsigned i = 0; i <= j; i++) begin
            term = grp_g[i];
            for (int unsigned k = i + 1; k <= j; k++) begin
               term = term & grp_p[k];
            end
            acc = acc | term;
         end
         grp_c[j+1] = acc;
      end
   end

`ifdef CLA_OVERFLOW_EN
   logic [2:0] top_g;
   logic [2:0] top_p;
   logic       c31;
   logic       overflow_c;

   assign top_g = in_1[30:28] & in_2[30:28];
   assign top_p = in_1[30:28] ^ in_2[30:28];

   // Carry into the MSB, looked ahead from the group carry c28.
   assign c31 = top_g[2] | (top_p[2] & top_g[1]) | (top_p[2] & top_p[1] & top_g[0])
              | (top_p[2] & top_p[1] & top_p[0] & grp_c[CLA_NGROUPS-1]);
   assign overflow_c = c31 ^ grp_c[CLA_NGROUPS];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum      <= '0;
         c_out    <= 1'b0;
`ifdef CLA_OVERFLOW_EN
         overflow <= 1'b0;
`endif
      end else begin
         sum      <= sum_c;
         c_out    <= grp_c[CLA_NGROUPS];
`ifdef CLA_OVERFLOW_EN
         overflow <= overflow_c;
`endif
      end
   end

endmodule : carry_look_ahead

// File: tb/tb_carry_look_ahead.sv
// Directed and random bench for carry_look_ahead; overflow checked when CLA_OVERFLOW_EN is defined.
module tb_carry_look_ahead;

   logic        clk;
   logic        rst;
   logic [31:0] sum;
   logic        c_out;
   logic        c_in;
   logic [31:0] in_1;
   logic [31:0] in_2;
`ifdef CLA_OVERFLOW_EN
   logic        overflow;
`endif

   int n_asrt;
   int n_fail;

   carry_look_ahead dut (
      .clk      (clk),
      .rst      (rst),
      .sum      (sum),
      .c_out    (c_out),
      .c_in     (c_in),
      .in_1     (in_1),
      .in_2     (in_2)
`ifdef CLA_OVERFLOW_EN
      ,
      .overflow (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asrt++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drive operands at the falling edge, sample one rising edge later.
   task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] exp_sum, input logic exp_co);
      @(negedge clk);
      in_1 = a;
      in_2 = b;
      c_in = ci;
      @(posedge clk);
      #1;
      check({tag, ".sum"}, sum, exp_sum);
      check({tag, ".c_out"}, 32'(c_out), 32'(exp_co));
   endtask

   initial begin
      logic [32:0] ref_full;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic [31:0] held;
      n_asrt = 0;
      n_fail = 0;
      rst    = 1'b0;
      c_in   = 1'b0;
      in_1   = 32'd546546;
      in_2   = 32'd123564;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      check("reset.sum", sum, 32'd0);
      check("reset.c_out", 32'(c_out), 32'd0);
`ifdef CLA_OVERFLOW_EN
      check("reset.overflow", 32'(overflow), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      step("v0", 32'd546546, 32'd123564, 1'b0, 32'd670110, 1'b0);
      step("v1", 32'(-345957), 32'd213568, 1'b0, 32'(-132389), 1'b0);
      step("v2", 32'(-654668), 32'd889401, 1'b0, 32'd234733, 1'b1);
      step("v3", 32'(-23132198), 32'(-46565454), 1'b0, 32'(-69697652), 1'b1);
      step("v4", 32'd686868, 32'd796521, 1'b1, 32'd1483390, 1'b0);
      step("v5", 32'(-456445123), 32'd6498423, 1'b1, 32'(-449946699), 1'b0);
      step("v6", 32'd546551, 32'(-1987658), 1'b1, 32'(-1441106), 1'b0);
      step("v7", 32'(-9987232), 32'(-9812312), 1'b1, 32'(-19799543), 1'b1);

      step("full_carry", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
      step("max_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
`ifdef CLA_OVERFLOW_EN
      check("max_pos.overflow", 32'(overflow), 32'd1);
`endif
      step("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1);

      // Operands changing between edges must not disturb the held result
      @(negedge clk);
      in_1 = 32'h1234_5678;
      in_2 = 32'h1111_1111;
      c_in = 1'b0;
      #1;
      check("hold.sum", sum, 32'h0000_0000);
      check("hold.c_out", 32'(c_out), 32'd1);
      @(posedge clk);
      #1;
      check("hold_load.sum", sum, 32'h2345_6789);

      // Mid-stream reset: clears at once, first edge after release loads current operands
      @(negedge clk);
      in_1 = 32'd1;
      in_2 = 32'd2;
      c_in = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("mid_rst.sum", sum, 32'd0);
      check("mid_rst.c_out", 32'(c_out), 32'd0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst.sum", sum, 32'd3);
      check("post_rst.c_out", 32'(c_out), 32'd0);

      // Back-to-back random operands against a 33-bit reference
      held = 32'd0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         ra   = $urandom;
         rb   = $urandom;
         rc   = 1'($urandom_range(0, 1));
         in_1 = ra;
         in_2 = rb;
         c_in = rc;
         ref_full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
         @(posedge clk);
         #1;
         check("rand.sum", sum, ref_full[31:0]);
         check("rand.c_out", 32'(c_out), 32'(ref_full[32]));
`ifdef CLA_OVERFLOW_EN
         check("rand.overflow", 32'(overflow),
               32'((ra[31] == rb[31]) && (ref_full[31] != ra[31])));
`endif
         held = ref_full[31:0];
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule : tb_carry_look_ahead
